// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock, LSB first, registered carry between digits.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_r, state_nx_s;
   logic               busy_r, done_r, busy_nx_s, done_nx_s;
   logic [WIDTH-1:0]   a_sh_r, b_sh_r, sum_sh_r, sum_r;
   logic               c_r, cout_r, ovf_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               last_s;
   logic [WIDTH-1:0]   b_ld_s;
   logic               c_ld_s;
   logic [DIGIT:0]     carry_s;
   logic [DIGIT-1:0]   dsum_s;
   logic [WIDTH-1:0]   dsum_ext_s, sum_nx_s;

   assign last_s = (cnt_r == CNT_W'(N - 1));

   // Operand conditioning at capture time (subtract folds into ~b with forced carry-in)
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) begin
         b_ld_s = ~b;
         c_ld_s = 1'b1;
      end else begin
         b_ld_s = b;
         c_ld_s = cin;
      end
`else
      b_ld_s = b;
      c_ld_s = cin;
`endif
   end

   // DIGIT-wide ripple chain of full adders and the shifted partial sum
   always_comb begin
      carry_s    = '0;
      dsum_s     = '0;
      dsum_ext_s = '0;
      carry_s[0] = c_r;
      for (int i = 0; i < DIGIT; i++) begin
         dsum_s[i]      = a_sh_r[i] ^ b_sh_r[i] ^ carry_s[i];
         carry_s[i + 1] = (a_sh_r[i] & b_sh_r[i]) | (carry_s[i] & (a_sh_r[i] ^ b_sh_r[i]));
      end
      dsum_ext_s[DIGIT-1:0] = dsum_s;
      sum_nx_s = (sum_sh_r >> DIGIT) | (dsum_ext_s << (WIDTH - DIGIT));
   end

   // State register plus registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= busy_nx_s;
         done_r  <= done_nx_s;
      end
   end

   // Next-state logic; start only matters in IDLE
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nx_s = ST_RUN;
            else       state_nx_s = ST_IDLE;
         end
         ST_RUN: begin
            if (last_s) state_nx_s = ST_DONE;
            else        state_nx_s = ST_RUN;
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Status flags decoded from the upcoming state so they register alongside it
   always_comb begin
      busy_nx_s = 1'b0;
      done_nx_s = 1'b0;
      case (state_nx_s)
         ST_RUN:  busy_nx_s = 1'b1;
         ST_DONE: done_nx_s = 1'b1;
         default: begin
            busy_nx_s = 1'b0;
            done_nx_s = 1'b0;
         end
      endcase
   end

   // Datapath: operand capture, digit shifting, and result commit on the last digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         sum_sh_r <= '0;
         c_r      <= 1'b0;
         cnt_r    <= '0;
         sum_r    <= '0;
         cout_r   <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  a_sh_r   <= a;
                  b_sh_r   <= b_ld_s;
                  c_r      <= c_ld_s;
                  cnt_r    <= '0;
                  sum_sh_r <= '0;
               end
            end
            ST_RUN: begin
               a_sh_r   <= a_sh_r >> DIGIT;
               b_sh_r   <= b_sh_r >> DIGIT;
               sum_sh_r <= sum_nx_s;
               c_r      <= carry_s[DIGIT];
               cnt_r    <= cnt_r + CNT_W'(1);
               if (last_s) begin
                  sum_r  <= sum_nx_s;
                  cout_r <= carry_s[DIGIT];
                  ovf_r  <= carry_s[DIGIT] ^ carry_s[DIGIT-1];
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;
   assign ovf  = ovf_r;

endmodule
